// File: rtl/i2c_eeprom_master.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : i2c_eeprom_master
// Brief    : I2C master for 13-bit-address EEPROMs: byte write and random read.
//            Define I2C_ACK_CHECK_EN to abort on a slave NACK and flag ack_err.
// Revision : 1.0
// =============================================================================
module i2c_eeprom_master #(
    parameter int CLK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rw,
    input  logic [2:0]  dev_addr,
    input  logic [12:0] mem_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_START   = 4'd1,
        S_CTRL_W  = 4'd2,
        S_ADDR_H  = 4'd3,
        S_ADDR_L  = 4'd4,
        S_WDATA   = 4'd5,
        S_RESTART = 4'd6,
        S_CTRL_R  = 4'd7,
        S_RDATA   = 4'd8,
        S_MNACK   = 4'd9,
        S_STOP    = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       bit_q, bit_d;
    logic             rw_q, rw_d;
    logic [2:0]       dev_q, dev_d;
    logic [12:0]      addr_q, addr_d;
    logic [7:0]       wdat_q, wdat_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
`ifdef I2C_ACK_CHECK_EN
    logic             nack_q, nack_d;
    logic             ack_err_q, ack_err_d;
`endif

    logic             w_sda_in;
    logic             w_is_byte;
    logic [7:0]       w_tx;
    logic             w_drive;
    state_t           w_next_byte;

    assign w_sda_in = sda;

    // Per-state byte to transmit, the SDA level for the next data-change point,
    // and the successor of each byte state.
    always_comb begin
        w_is_byte   = 1'b0;
        w_tx        = 8'hFF;
        w_next_byte = S_STOP;
        case (state_q)
            S_CTRL_W: begin w_is_byte = 1'b1; w_tx = {4'b1010, dev_q, 1'b0}; w_next_byte = S_ADDR_H; end
            S_ADDR_H: begin w_is_byte = 1'b1; w_tx = {3'b000, addr_q[12:8]};  w_next_byte = S_ADDR_L; end
            S_ADDR_L: begin
                w_is_byte   = 1'b1;
                w_tx        = addr_q[7:0];
                w_next_byte = rw_q ? S_RESTART : S_WDATA;
            end
            S_WDATA:  begin w_is_byte = 1'b1; w_tx = wdat_q;                   w_next_byte = S_STOP; end
            S_CTRL_R: begin w_is_byte = 1'b1; w_tx = {4'b1010, dev_q, 1'b1}; w_next_byte = S_RDATA; end
            default:  ;
        endcase
        w_drive = 1'b0;
        if (state_q == S_STOP) begin
            w_drive = 1'b1;
        end else if (w_is_byte && bit_q != 4'd8) begin
            w_drive = ~w_tx[3'd7 - bit_q[2:0]];
        end
    end

    // Each SCL period is four phases: 0/1 SCL low, 2/3 SCL high. SDA changes
    // on entry to phase 1 and is sampled on entry to phase 3.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        scl_d     = scl_q;
        sda_oe_d  = sda_oe_q;
`ifdef I2C_ACK_CHECK_EN
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
`endif
        if (state_q == S_IDLE) begin
            if (start) begin
                rw_d     = rw;
                dev_d    = dev_addr;
                addr_d   = mem_addr;
                wdat_d   = wr_data;
                busy_d   = 1'b1;
                state_d  = S_START;
                div_d    = '0;
                phase_d  = 2'd0;
                bit_d    = 4'd0;
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
`ifdef I2C_ACK_CHECK_EN
                ack_err_d = 1'b0;
                nack_d    = 1'b0;
`endif
            end
        end else if (state_q == S_STOP && phase_q == 2'd3) begin
            // SDA rose on the previous edge: the transaction is complete.
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            div_d    = '0;
            phase_d  = 2'd0;
            scl_d    = 1'b1;
            sda_oe_d = 1'b0;
        end else if (div_q != C_DIV_LAST) begin
            div_d = div_q + C_DIV_ONE;
        end else begin
            div_d   = '0;
            phase_d = phase_q + 2'd1;
            scl_d   = (state_q == S_START && phase_q != 2'd3) ? 1'b1 : phase_d[1];
            case (phase_q)
                2'd0: sda_oe_d = w_drive;
                2'd2: begin
                    if (state_q == S_START || state_q == S_RESTART) begin
                        sda_oe_d = 1'b1;
                    end else if (state_q == S_STOP) begin
                        sda_oe_d = 1'b0;
                    end else if (state_q == S_RDATA) begin
                        rx_d = {rx_q[6:0], w_sda_in};
                    end
`ifdef I2C_ACK_CHECK_EN
                    if (w_is_byte && bit_q == 4'd8) begin
                        nack_d = w_sda_in;
                    end
`endif
                end
                2'd3: begin
                    case (state_q)
                        S_START:   state_d = S_CTRL_W;
                        S_RESTART: state_d = S_CTRL_R;
                        S_MNACK:   state_d = S_STOP;
                        S_RDATA: begin
                            if (bit_q == 4'd7) begin
                                bit_d     = 4'd0;
                                rd_data_d = rx_q;
                                state_d   = S_MNACK;
                            end else begin
                                bit_d = bit_q + 4'd1;
                            end
                        end
                        default: begin
                            if (bit_q != 4'd8) begin
                                bit_d = bit_q + 4'd1;
                            end else begin
                                bit_d   = 4'd0;
                                state_d = w_next_byte;
`ifdef I2C_ACK_CHECK_EN
                                if (nack_q) begin
                                    state_d   = S_STOP;
                                    ack_err_d = 1'b1;
                                end
`endif
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 4'd0;
            rw_q      <= 1'b0;
            dev_q     <= 3'd0;
            addr_q    <= 13'd0;
            wdat_q    <= 8'd0;
            rx_q      <= 8'd0;
            rd_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
`ifdef I2C_ACK_CHECK_EN
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
`endif
        end
    end

    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign scl     = scl_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
`ifdef I2C_ACK_CHECK_EN
    assign ack_err = ack_err_q;
`else
    assign ack_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_master.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_i2c_eeprom_master
// Brief    : Directed bench for i2c_eeprom_master with a behavioural EEPROM slave.
// Revision : 1.0
// =============================================================================
module tb_i2c_eeprom_master;

    localparam int CLK_DIV = 4;
    localparam int PER     = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst, start, rw;
    logic [2:0]  dev_addr;
    logic [12:0] mem_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        busy, done, ack_err, scl;
    wire         sda;
    logic        s_oe = 1'b0;
    logic        s_present = 1'b1;

    pullup (sda);
    assign sda = s_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_eeprom_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
        .mem_addr(mem_addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
        .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
    );

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem [0:8191];
    logic [7:0]  bus_log [$];
    int          start_cnt, stop_cnt, done_cnt;
    logic        m_nack;

    initial begin : done_counter
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    // EEPROM slave: detects START/STOP, logs every byte the master sends,
    // ACKs when present, stores write data and returns mem[ptr] on a read.
    initial begin : slave_model
        logic ps, pd, cs, cd, rd_mode, tx_mode;
        logic [7:0] rx, txb;
        logic [12:0] ptr;
        int nbit, nbyte;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        ps = 1'b1; pd = 1'b1; rx = 8'h00; txb = 8'h00; ptr = 13'd0;
        nbit = 0; nbyte = 0; rd_mode = 1'b0; tx_mode = 1'b0;
        start_cnt = 0; stop_cnt = 0; m_nack = 1'b0;
        forever begin
            @(negedge clk);
            cs = (scl !== 1'b0);
            cd = (sda !== 1'b0);
            if (ps && cs && pd && !cd) begin
                start_cnt++; nbit = 0; nbyte = 0; tx_mode = 1'b0; s_oe = 1'b0;
            end else if (ps && cs && !pd && cd) begin
                stop_cnt++; nbit = 0; tx_mode = 1'b0; s_oe = 1'b0;
            end else if (!ps && cs) begin
                if (nbit < 8) rx = {rx[6:0], cd};
                else if (nbit == 8 && tx_mode) m_nack = cd;
                nbit++;
            end else if (ps && !cs) begin
                if (nbit == 8) begin
                    if (tx_mode) begin
                        s_oe = 1'b0;
                    end else begin
                        bus_log.push_back(rx);
                        case (nbyte)
                            0: rd_mode = rx[0];
                            1: ptr[12:8] = rx[4:0];
                            2: ptr[7:0] = rx;
                            default: begin
                                if (s_present) mem[ptr] = rx;
                                ptr++;
                            end
                        endcase
                        nbyte++;
                        s_oe = s_present;
                    end
                end else if (nbit == 9) begin
                    nbit = 0; s_oe = 1'b0;
                    if (tx_mode) begin
                        tx_mode = 1'b0;
                    end else if (rd_mode && nbyte == 1 && s_present) begin
                        tx_mode = 1'b1; txb = mem[ptr]; s_oe = ~txb[7];
                    end
                end else if (tx_mode && nbit >= 1 && nbit <= 7) begin
                    s_oe = ~txb[7-nbit];
                end
            end
            ps = cs; pd = cd;
        end
    end

    // {byte count, first four logged bytes}
    function automatic logic [39:0] pack_log();
        logic [39:0] p;
        p = '0;
        p[39:32] = 8'(bus_log.size());
        for (int i = 0; i < 4 && i < bus_log.size(); i++) p[31-8*i -: 8] = bus_log[i];
        return p;
    endfunction

    task automatic clear_bus();
        bus_log.delete(); start_cnt = 0; stop_cnt = 0; done_cnt = 0; m_nack = 1'b0;
    endtask

    task automatic run_txn(input logic r, input logic [2:0] d, input logic [12:0] a,
                           input logic [7:0] w, output int cyc, output logic timed_out,
                           output logic busy_acc, output logic busy_end);
        clear_bus();
        @(posedge clk); #1;
        rw = r; dev_addr = d; mem_addr = a; wr_data = w; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; busy_acc = busy;
        cyc = 0; timed_out = 1'b1;
        while (cyc < 4000) begin
            @(negedge clk); cyc++;
            if (done === 1'b1) begin timed_out = 1'b0; break; end
        end
        busy_end = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rw = 1'b0; dev_addr = 3'd0; mem_addr = 13'd0; wr_data = 8'd0;
        repeat (3) @(negedge clk);
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b expected 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda); end
        checks++; if ({busy, done, ack_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got busy/done/ack_err=%b expected 000", {busy, done, ack_err});
        end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2 * PER) @(negedge clk);
        checks++; if (busy !== 1'b0 || start_cnt != 0) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b starts=%0d expected 0/0", busy, start_cnt);
        end
    endtask

    task automatic test_write();
        int cyc; logic to, ba, be;
        run_txn(1'b0, 3'd0, 13'h0123, 8'hA5, cyc, to, ba, be);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL write_done_timeout: got no done expected done"); end
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL write_busy_accept: got %b expected 1", ba); end
        checks++; if (be !== 1'b0) begin errors++; $display("FAIL write_busy_at_done: got %b expected 0", be); end
        checks++; if (pack_log() !== {8'd4, 32'hA001_23A5}) begin
            errors++; $display("FAIL write_bus_bytes: got %h expected 04a00123a5", pack_log());
        end
        checks++; if (start_cnt != 1 || stop_cnt != 1) begin
            errors++; $display("FAIL write_start_stop: got %0d/%0d expected 1/1", start_cnt, stop_cnt);
        end
        checks++; if (mem[13'h0123] !== 8'hA5) begin errors++; $display("FAIL write_mem: got %h expected a5", mem[13'h0123]); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL write_ack_err: got %b expected 0", ack_err); end
        checks++; if (cyc < 38 * PER - PER || cyc > 38 * PER + PER) begin
            errors++; $display("FAIL write_duration: got %0d cycles expected %0d +/- %0d", cyc, 38 * PER, PER);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || done_cnt != 1) begin
            errors++; $display("FAIL write_done_pulse: got done=%b count=%0d expected 0/1", done, done_cnt);
        end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL write_rd_hold: got %h expected 00", rd_data); end
    endtask

    task automatic test_read();
        int cyc; logic to, ba, be;
        run_txn(1'b1, 3'd0, 13'h0123, 8'h00, cyc, to, ba, be);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL read_done_timeout: got no done expected done"); end
        checks++; if (pack_log() !== {8'd4, 32'hA001_23A1}) begin
            errors++; $display("FAIL read_bus_bytes: got %h expected 04a00123a1", pack_log());
        end
        checks++; if (start_cnt != 2 || stop_cnt != 1) begin
            errors++; $display("FAIL read_start_stop: got %0d/%0d expected 2/1", start_cnt, stop_cnt);
        end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL read_data: got %h expected a5", rd_data); end
        checks++; if (m_nack !== 1'b1) begin errors++; $display("FAIL read_master_nack: got %b expected 1", m_nack); end
        checks++; if (cyc < 48 * PER - PER || cyc > 48 * PER + PER) begin
            errors++; $display("FAIL read_duration: got %0d cycles expected %0d +/- %0d", cyc, 48 * PER, PER);
        end
        checks++; if (be !== 1'b0 || done_cnt != 1) begin
            errors++; $display("FAIL read_done_busy: got busy=%b dones=%0d expected 0/1", be, done_cnt);
        end
    endtask

    task automatic test_high_addr();
        int cyc; logic to, ba, be;
        run_txn(1'b0, 3'b111, 13'h1FFF, 8'h3C, cyc, to, ba, be);
        checks++; if (to !== 1'b0 || pack_log() !== {8'd4, 32'hAE1F_FF3C}) begin
            errors++; $display("FAIL high_write_bus: got %h expected 04ae1fff3c", pack_log());
        end
        checks++; if (mem[13'h1FFF] !== 8'h3C) begin errors++; $display("FAIL high_write_mem: got %h expected 3c", mem[13'h1FFF]); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL high_rd_hold: got %h expected a5", rd_data); end
        run_txn(1'b1, 3'b111, 13'h1FFF, 8'h00, cyc, to, ba, be);
        checks++; if (to !== 1'b0 || pack_log() !== {8'd4, 32'hAE1F_FFAF}) begin
            errors++; $display("FAIL high_read_bus: got %h expected 04ae1fffaf", pack_log());
        end
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL high_read_data: got %h expected 3c", rd_data); end
    endtask

    task automatic test_no_slave();
        int cyc; logic to, ba, be;
        s_present = 1'b0;
        run_txn(1'b0, 3'd0, 13'h0055, 8'h77, cyc, to, ba, be);
        checks++; if (to !== 1'b0 || be !== 1'b0 || stop_cnt != 1) begin
            errors++; $display("FAIL noslave_end: got timeout=%b busy=%b stops=%0d expected 0/0/1", to, be, stop_cnt);
        end
`ifdef I2C_ACK_CHECK_EN
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL noslave_ack_err: got %b expected 1", ack_err); end
        checks++; if (pack_log() !== {8'd1, 32'hA000_0000}) begin
            errors++; $display("FAIL noslave_bus: got %h expected 01a0000000", pack_log());
        end
        checks++; if (cyc < 11 * PER - PER || cyc > 11 * PER + PER) begin
            errors++; $display("FAIL noslave_duration: got %0d cycles expected %0d +/- %0d", cyc, 11 * PER, PER);
        end
        run_txn(1'b1, 3'd0, 13'h0055, 8'h00, cyc, to, ba, be);
        checks++; if (rd_data !== 8'h3C || ack_err !== 1'b1) begin
            errors++; $display("FAIL noslave_read: got rd=%h ack_err=%b expected 3c/1", rd_data, ack_err);
        end
`else
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL noslave_ack_err: got %b expected 0", ack_err); end
        checks++; if (pack_log() !== {8'd4, 32'hA000_5577}) begin
            errors++; $display("FAIL noslave_bus: got %h expected 04a0005577", pack_log());
        end
        checks++; if (cyc < 38 * PER - PER || cyc > 38 * PER + PER) begin
            errors++; $display("FAIL noslave_duration: got %0d cycles expected %0d +/- %0d", cyc, 38 * PER, PER);
        end
        run_txn(1'b1, 3'd0, 13'h0055, 8'h00, cyc, to, ba, be);
        checks++; if (rd_data !== 8'hFF || ack_err !== 1'b0) begin
            errors++; $display("FAIL noslave_read: got rd=%h ack_err=%b expected ff/0", rd_data, ack_err);
        end
`endif
        s_present = 1'b1;
    endtask

    task automatic test_busy_guard();
        int n;
        clear_bus();
        @(posedge clk); #1;
        rw = 1'b0; dev_addr = 3'd0; mem_addr = 13'h0200; wr_data = 8'h5A; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10 * PER) @(negedge clk);
        rw = 1'b1; dev_addr = 3'b101; mem_addr = 13'h0300; wr_data = 8'h11; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        repeat (5 * PER) @(negedge clk);
        checks++; if (busy !== 1'b0 || done_cnt != 1 || start_cnt != 1 || stop_cnt != 1) begin
            errors++; $display("FAIL guard_single_txn: got busy=%b dones=%0d starts=%0d stops=%0d expected 0/1/1/1",
                               busy, done_cnt, start_cnt, stop_cnt);
        end
        checks++; if (pack_log() !== {8'd4, 32'hA002_005A}) begin
            errors++; $display("FAIL guard_bus: got %h expected 04a002005a", pack_log());
        end
        checks++; if (mem[13'h0200] !== 8'h5A || ack_err !== 1'b0) begin
            errors++; $display("FAIL guard_mem: got %h ack_err=%b expected 5a/0", mem[13'h0200], ack_err);
        end
    endtask

    task automatic test_reset_mid();
        int n, cyc; logic to, ba, be;
        clear_bus();
        @(posedge clk); #1;
        rw = 1'b0; dev_addr = 3'd0; mem_addr = 13'h0456; wr_data = 8'hC3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (bus_log.size() < 1 && n < 2000) begin @(negedge clk); n++; end
        checks++; if (bus_log.size() < 1) begin errors++; $display("FAIL midrst_ctrl_timeout: got no control byte expected a0"); end
        repeat (PER + 8) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got scl=%b sda=%b busy=%b done=%b expected 1/1/0/0", scl, sda, busy, done);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (mem[13'h0456] !== 8'h00) begin errors++; $display("FAIL midrst_no_write: got %h expected 00", mem[13'h0456]); end
        run_txn(1'b0, 3'd0, 13'h0456, 8'hC3, cyc, to, ba, be);
        checks++; if (to !== 1'b0 || pack_log() !== {8'd4, 32'hA004_56C3} || mem[13'h0456] !== 8'hC3) begin
            errors++; $display("FAIL midrst_recover: got bus=%h mem=%h expected 04a00456c3/c3", pack_log(), mem[13'h0456]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_high_addr();
        test_no_slave();
        test_busy_guard();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
